// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph constants, digit count and capture FSM states.
// The display encoder and the capture decoder both index GLYPHS so their tables cannot drift.
package seg_pkg;
  localparam int NUM_DIGITS = 8;

  // Active-low segments, bit 6 = seg g ... bit 0 = seg a.
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  localparam logic [15:0][6:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;
endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational segment-pattern to hex-nibble decoder; legal is low for any
// pattern outside the glyph table (nibble is then 0).
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [6:0] z,
  output logic [3:0] nibble,
  output logic       legal
);
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (z == GLYPHS[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg_capture.sv
// Recovers hex digits from a multiplexed seven-segment drive: pins are sampled once,
// must hold STABLE_CYCLES+1 edges, then are captured exactly once per stable interval.
module seg_capture
  import seg_pkg::*;
#(
  parameter int          STABLE_CYCLES = 4,
  parameter logic [7:0]  FRAME_MASK    = 8'hFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_DIGITS-1:0]     a,
  input  logic [6:0]                z,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      frame_done,
  output logic                      err_pattern,
  output logic                      err_anode,
  output logic [7:0]                err_count
);
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [7:0]              cnt;
  logic [NUM_DIGITS-1:0]   s_a;
  logic [6:0]              s_z;
  logic [NUM_DIGITS-1:0]   tracking;
  logic [NUM_DIGITS-1:0]   set_bits;
  logic [3:0]              nibble;
  logic                    legal;
  logic                    changed, capture, blank, one_low;
  logic                    digit_wr, pat_err, an_err;

  seg_glyph_dec u_dec (
    .z      (s_z),
    .nibble (nibble),
    .legal  (legal)
  );

  // A change is seen as the new sample is loaded, so the counter restarts on that same edge.
  assign changed = ({a, z} != {s_a, s_z});
  assign blank   = &s_a;
  assign one_low = $onehot(~s_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (changed) begin
      state_nxt = SETTLE;
    end else begin
      case (state)
        SETTLE:  if (cnt == LAST) state_nxt = HELD;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    capture  = (state == SETTLE) && !changed && (cnt == LAST);
    digit_wr = capture && one_low;
    pat_err  = digit_wr && !legal;
    an_err   = capture && !blank && !one_low;
    set_bits = (digit_wr && legal) ? ~s_a : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_a         <= '1;
      s_z         <= '1;
      cnt         <= 8'd0;
      digits      <= '0;
      digit_valid <= '0;
      tracking    <= '0;
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      s_a <= a;
      s_z <= z;
      if (changed)                           cnt <= 8'd0;
      else if (state == SETTLE && !capture)  cnt <= cnt + 8'd1;

      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (digit_wr && !s_a[k]) begin
          if (legal) digits[4*k +: 4] <= nibble;
          digit_valid[k] <= legal;
        end
      end

      // Completion is registered: the pulse and the clear land one edge after the last capture.
      if ((tracking & FRAME_MASK) == FRAME_MASK) begin
        frame_done <= 1'b1;
        tracking   <= set_bits;
      end else begin
        frame_done <= 1'b0;
        tracking   <= tracking | set_bits;
      end

      err_pattern <= pat_err;
      err_anode   <= an_err;
      if ((pat_err || an_err) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture with STABLE_CYCLES=4, FRAME_MASK=8'hFF.
module tb_seg_capture;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a   = 8'hFF;
  logic [6:0]  z   = 7'h7F;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_done, err_pattern, err_anode;
  logic [7:0]  err_count;

  int passed = 0;
  int checks = 0;
  int fd_cnt = 0;
  int ep_cnt = 0;
  int ea_cnt = 0;

  seg_capture #(.STABLE_CYCLES(4), .FRAME_MASK(8'hFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .z           (z),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_pattern (err_pattern),
    .err_anode   (err_anode),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later, tallying output pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (frame_done)  fd_cnt++;
      if (err_pattern) ep_cnt++;
      if (err_anode)   ea_cnt++;
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_digits", digits, 32'h0);
    check("rst_valid", {24'h0, digit_valid}, 32'h0);
    check("rst_pulses", {29'h0, frame_done, err_pattern, err_anode}, 32'h0);
    check("rst_errcnt", {24'h0, err_count}, 32'h0);
    rst = 1'b0;

    // Single digit: capture lands on edge 5 and then holds
    a = 8'hFE; z = 7'b0100100;
    tick(4);
    check("d0_early_valid", {24'h0, digit_valid}, 32'h0);
    tick(1);
    check("d0_valid", {24'h0, digit_valid}, 32'h01);
    check("d0_digits", digits, 32'h2);
    tick(5);
    check("d0_hold_digits", digits, 32'h2);
    check("d0_hold_valid", {24'h0, digit_valid}, 32'h01);

    // Full frame scan, glyph k on digit k
    fd_cnt = 0;
    for (int d = 0; d < 7; d++) begin
      a = ~(8'h01 << d); z = GLYPHS[d];
      tick(6);
    end
    a = 8'h7F; z = GLYPH_7;
    tick(5);
    check("frame_no_early_pulse", {31'h0, frame_done}, 32'h0);
    tick(1);
    check("frame_pulse", {31'h0, frame_done}, 32'h1);
    a = 8'hFF; z = 7'h7F;
    tick(6);
    check("frame_pulse_count", fd_cnt, 32'd1);
    check("frame_digits", digits, 32'h76543210);
    check("frame_valid", {24'h0, digit_valid}, 32'hFF);

    // Illegal glyph on digit 2
    ep_cnt = 0; ea_cnt = 0;
    a = 8'hFB; z = 7'b1111111;
    tick(6);
    check("pat_pulses", ep_cnt, 32'd1);
    check("pat_valid", {24'h0, digit_valid}, 32'hFB);
    check("pat_digits", digits, 32'h76543210);
    check("pat_errcnt", {24'h0, err_count}, 32'd1);

    // Two anodes low
    ep_cnt = 0; ea_cnt = 0;
    a = 8'hFC; z = GLYPH_8;
    tick(6);
    check("anode_pulses", ea_cnt, 32'd1);
    check("anode_digits", digits, 32'h76543210);
    check("anode_errcnt", {24'h0, err_count}, 32'd2);

    // Segments toggling every cycle never settle
    ep_cnt = 0; ea_cnt = 0;
    a = 8'hFE;
    for (int i = 0; i < 50; i++) begin
      z = (i % 2 == 0) ? GLYPH_8 : GLYPH_9;
      tick(1);
    end
    check("glitch_digits", digits, 32'h76543210);
    check("glitch_errs", ep_cnt + ea_cnt, 32'd0);
    check("glitch_errcnt", {24'h0, err_count}, 32'd2);

    // Reset mid-settle discards progress
    a = 8'hFD; z = GLYPH_9;
    tick(3);
    rst = 1'b1;
    #1;
    check("midrst_digits", digits, 32'h0);
    check("midrst_errcnt", {24'h0, err_count}, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(4);
    check("postrst_early_valid", {24'h0, digit_valid}, 32'h0);
    tick(1);
    check("postrst_valid", {24'h0, digit_valid}, 32'h02);
    check("postrst_digits", digits, 32'h90);

    // Error counter saturation over 300 illegal captures
    ep_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      a = (i % 2 == 0) ? 8'hFE : 8'hFD; z = 7'h7F;
      tick(5);
      if (i == 254) check("sat_errcnt_255", {24'h0, err_count}, 32'd255);
    end
    check("sat_pulses", ep_cnt, 32'd300);
    check("sat_errcnt", {24'h0, err_count}, 32'd255);
    check("sat_valid", {24'h0, digit_valid}, 32'h0);
    check("sat_digits", digits, 32'h90);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
